// File: rtl/aes_decrypt_iterative.sv
// Iterative AES inverse cipher: one inverse round per clock over a shared datapath.
// Optional macro AES_DEC_ABORT_EN adds an abort input that cancels an in-flight block.
module aes_decrypt_iterative #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned KIDX_W     = $clog2(NUM_ROUNDS + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    output logic [KIDX_W-1:0] key_index,
    input  logic [127:0]      key_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef AES_DEC_ABORT_EN
    input  logic              abort,
`endif
    output logic [127:0]      out_data
);

    typedef enum logic [1:0] {StIdle, StRound, StDone} fsm_e;

    localparam logic [KIDX_W-1:0] LastIdx = KIDX_W'(NUM_ROUNDS);

    // Byte 0 of the block is bits [127:120]; byte 4*c+r is row r of column c.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] t;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        return t;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] t;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            t[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
        end
        return t;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] t;
        logic [7:0]   a0;
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [7:0]   a3;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            t[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^
                                   gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            t[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^
                                   gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            t[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^
                                   gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            t[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^
                                   gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return t;
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [127:0] t;
        t = inv_sub_bytes(inv_shift_rows(s)) ^ k;
        if (!last) begin
            t = inv_mix_columns(t);
        end
        return t;
    endfunction

    fsm_e              r_fsm;
    fsm_e              w_fsm_nxt;
    logic [127:0]      r_state;
    logic [127:0]      w_state_nxt;
    logic [KIDX_W-1:0] r_rnd;
    logic [KIDX_W-1:0] w_rnd_nxt;
    logic [KIDX_W-1:0] w_rnd_m1;
    logic              w_last;
    logic [127:0]      w_round_out;

    assign w_rnd_m1    = r_rnd - KIDX_W'(1);
    assign w_last      = (w_rnd_m1 == '0);
    assign w_round_out = inv_round(r_state, key_data, w_last);

    assign in_ready  = (r_fsm == StIdle);
    assign out_valid = (r_fsm == StDone);
    assign out_data  = r_state;

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_rnd_nxt   = r_rnd;
        key_index   = r_rnd;
        unique case (r_fsm)
            StIdle: begin
                key_index = LastIdx;
                if (in_valid) begin
                    w_state_nxt = in_data ^ key_data;
                    w_rnd_nxt   = LastIdx;
                    w_fsm_nxt   = StRound;
                end
            end
            StRound: begin
                key_index   = w_rnd_m1;
                w_state_nxt = w_round_out;
                w_rnd_nxt   = w_rnd_m1;
                if (w_last) begin
                    w_fsm_nxt = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_fsm_nxt = StIdle;
                    w_rnd_nxt = LastIdx;
                end
            end
            default: begin
                w_fsm_nxt = StIdle;
                w_rnd_nxt = LastIdx;
            end
        endcase
`ifdef AES_DEC_ABORT_EN
        // Abort wins over the output handshake; idle blocks ignore it.
        if (abort && (r_fsm != StIdle)) begin
            w_fsm_nxt   = StIdle;
            w_rnd_nxt   = LastIdx;
            w_state_nxt = '0;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fsm   <= StIdle;
            r_rnd   <= LastIdx;
            r_state <= '0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_rnd   <= w_rnd_nxt;
            r_state <= w_state_nxt;
        end
    end

endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// Scoreboard bench for aes_decrypt_iterative: expected plaintexts come from FIPS-197 C.1
// constants and from an independent forward-cipher model encrypting random plaintexts.
module tb_aes_decrypt_iterative;

    localparam logic [127:0] KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] STEP0 = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] STEP1 = 128'h54d990a16ba09ab596bbf40ea111702f;

    logic         clock     = 1'b0;
    logic         reset     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [127:0] in_data   = '0;
    logic [3:0]   key_index;
    logic [127:0] key_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
`ifdef AES_DEC_ABORT_EN
    logic         abort     = 1'b0;
`endif

    aes_decrypt_iterative dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .key_index (key_index),
        .key_data  (key_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef AES_DEC_ABORT_EN
        .abort     (abort),
`endif
        .out_data  (out_data)
    );

    always #5 clock = ~clock;

    logic [7:0]   sbox [256];
    logic [127:0] rk   [11];
    assign key_data = (key_index <= 4'd10) ? rk[int'(key_index)] : '0;

    int           n_checks = 0;
    int           n_pass   = 0;
    int           cyc      = 0;
    int           last_out_cyc = 0;
    logic         prev_ov  = 1'b0;
    logic [127:0] drv_pt   = '0;
    logic [127:0] sb_q [$];
    int           acc_q [$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    task automatic build_tables();
        logic [7:0]  p;
        logic [7:0]  q;
        logic [7:0]  x;
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ xt(p);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = KEY[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t[31:24] = t[31:24] ^ rcon;
                rcon = xt(rcon);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    // Forward cipher, used only to turn random plaintexts into ciphertexts.
    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] s;
        logic [127:0] t;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[127 - 8 * i -: 8] = sbox[s[127 - 8 * i -: 8]];
            t = '0;
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[127 - 8 * (4 * c + w) -: 8] = s[127 - 8 * (4 * ((c + w) % 4) + w) -: 8];
            s = t;
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127 - 32 * c -: 8];
                    a1 = s[119 - 32 * c -: 8];
                    a2 = s[111 - 32 * c -: 8];
                    a3 = s[103 - 32 * c -: 8];
                    s[127 - 32 * c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[119 - 32 * c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[111 - 32 * c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[103 - 32 * c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            s = s ^ rk[r];
        end
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Monitor: push on input acceptance, check latency and pop on output handshake.
    always @(negedge clock) begin
        if (reset) begin
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                sb_q.push_back(drv_pt);
                acc_q.push_back(cyc);
            end
            if (out_valid && !prev_ov) begin
                if (acc_q.size() == 0) check("spurious_out_valid", 128'(out_valid), 128'(0));
                else check("latency", 128'(cyc - acc_q[0]), 128'(11));
            end
            if (out_valid && out_ready && sb_q.size() != 0) begin
                check("plaintext", out_data, sb_q.pop_front());
                void'(acc_q.pop_front());
                last_out_cyc = cyc;
            end
            prev_ov = out_valid;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offers one block and returns just after its acceptance edge.
    task automatic send(input logic [127:0] ct, input logic [127:0] pt);
        logic ok;
        ok = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data  = ct;
        drv_pt   = pt;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 128'(ok), 128'(1));
        tick();
        in_valid = 1'b0;
        in_data  = rand128();
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 128'(ok), 128'(1));
    endtask

    task automatic flush_sb();
        sb_q.delete();
        acc_q.delete();
    endtask

    initial begin
        repeat (20000) @(posedge clock);
        $display("FAIL watchdog: got no finish, expected finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] pa, pb;
        logic         ok;
        logic         ov_seen;
        int           acc2;
        build_tables();

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", out_data, 128'(0));
        check("rst_key_index", 128'(key_index), 128'(10));

        // FIPS-197 C.1 with intermediate state and key index sequence
        out_ready = 1'b1;
        send(CT, PT);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("key_index_round", 128'(key_index), 128'(9 - i));
            if (i == 0) check("step0_state", out_data, STEP0);
            if (i == 1) check("step1_state", out_data, STEP1);
            if (i == 5) check("busy_in_ready", 128'(in_ready), 128'(0));
        end
        wait_idle();
        check("idle_key_index", 128'(key_index), 128'(10));

        // Backpressure in DONE
        pa = rand128();
        tick();
        out_ready = 1'b0;
        send(encrypt(pa), pa);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_reached", 128'(ok), 128'(1));
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clock);
            check("stall_out_valid", 128'(out_valid), 128'(1));
            check("stall_in_ready", 128'(in_ready), 128'(0));
            check("stall_out_data", out_data, pa);
        end
        tick();
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("post_hs_in_ready", 128'(in_ready), 128'(1));
        check("post_hs_out_valid", 128'(out_valid), 128'(0));
        check("post_hs_out_data_held", out_data, pa);

        // Back-to-back with in_valid held high
        pa = rand128();
        pb = rand128();
        tick();
        in_valid = 1'b1;
        in_data  = encrypt(pa);
        drv_pt   = pa;
        @(negedge clock);
        tick();
        in_data = encrypt(pb);
        drv_pt  = pb;
        ok   = 1'b0;
        acc2 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (in_ready) begin
                ok   = 1'b1;
                acc2 = cyc;
                break;
            end
        end
        check("b2b_second_accept", 128'(ok), 128'(1));
        check("b2b_gap", 128'(acc2 - last_out_cyc), 128'(1));
        tick();
        in_valid = 1'b0;
        wait_idle();

        // Reset in the fourth ROUND cycle
        send(CT, PT);
        repeat (3) tick();
        reset = 1'b1;
        flush_sb();
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_in_ready", 128'(in_ready), 128'(1));
        check("mid_rst_out_valid", 128'(out_valid), 128'(0));
        check("mid_rst_out_data", out_data, 128'(0));
        check("mid_rst_key_index", 128'(key_index), 128'(10));
        send(CT, PT);
        wait_idle();

`ifdef AES_DEC_ABORT_EN
        send(CT, PT);
        repeat (5) tick();
        abort = 1'b1;
        flush_sb();
        tick();
        abort = 1'b0;
        @(negedge clock);
        check("abort_in_ready", 128'(in_ready), 128'(1));
        check("abort_out_data", out_data, 128'(0));
        ov_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            ov_seen = ov_seen | out_valid;
        end
        check("abort_no_out_valid", 128'(ov_seen), 128'(0));
        // Abort while idle must not block acceptance.
        abort = 1'b1;
        send(CT, PT);
        abort = 1'b0;
        wait_idle();
`else
        ov_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            ov_seen = ov_seen | out_valid;
        end
        check("idle_no_out_valid", 128'(ov_seen), 128'(0));
`endif

        repeat (3) tick();
        check("scoreboard_drained", 128'(sb_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
